// File: rtl/cam_capture_pkg.sv
// Shared camera-side definitions for the frame-buffer writer: capture FSM
// state encodings, default sensor geometry and the pixel packing helper.
package cam_capture_pkg;

  // Capture FSM states; the encodings are also decoded by the debug path.
  typedef enum logic [1:0] {
    S_WAIT_CFG = 2'd0,
    S_SKIP     = 2'd1,
    S_IDLE     = 2'd2,
    S_ACTIVE   = 2'd3
  } cam_state_e;

  // Default VGA frame geometry delivered by the sensor.
  localparam int CAM_H_ACTIVE     = 640;
  localparam int CAM_V_ACTIVE     = 480;
  localparam int CAM_FRAME_PIXELS = 307200;

  // The sensor sends the RGB565 high byte first; the word keeps that order.
  function automatic logic [15:0] pack_rgb565(input logic [7:0] hi_byte,
                                              input logic [7:0] lo_byte);
    return {hi_byte, lo_byte};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Camera input register stage: registers vsync/href/data once, keeps a
// second copy of vsync/href and derives single-cycle rise/fall strobes.
// All outputs are aligned to the registered (vs_q/hr_q/d_q) timeline.
module cam_sync_edge
  import cam_capture_pkg::*;
(
  input  logic       i_p_clk,
  input  logic       i_rstn,
  input  logic       i_vsync,
  input  logic       i_href,
  input  logic [7:0] i_data,
  output logic       o_vs,
  output logic       o_hr,
  output logic [7:0] o_data,
  output logic       o_vs_rise,
  output logic       o_vs_fall,
  output logic       o_hr_rise,
  output logic       o_hr_fall
);

  logic       vs_q, vs_d;
  logic       hr_q, hr_d;
  logic [7:0] d_q, d_d;
  logic       vs_dly_q, vs_dly_d;
  logic       hr_dly_q, hr_dly_d;

  // Next values: first stage samples the pins, second stage delays the strobes.
  always_comb begin
    vs_d     = i_vsync;
    hr_d     = i_href;
    d_d      = i_data;
    vs_dly_d = vs_q;
    hr_dly_d = hr_q;
  end

  // Input and delay registers with synchronous active-low reset.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      vs_q     <= 1'b0;
      hr_q     <= 1'b0;
      d_q      <= 8'd0;
      vs_dly_q <= 1'b0;
      hr_dly_q <= 1'b0;
    end else begin
      vs_q     <= vs_d;
      hr_q     <= hr_d;
      d_q      <= d_d;
      vs_dly_q <= vs_dly_d;
      hr_dly_q <= hr_dly_d;
    end
  end

  assign o_vs      = vs_q;
  assign o_hr      = hr_q;
  assign o_data    = d_q;
  assign o_vs_rise = vs_q & ~vs_dly_q;
  assign o_vs_fall = ~vs_q & vs_dly_q;
  assign o_hr_rise = hr_q & ~hr_dly_q;
  assign o_hr_fall = ~hr_q & hr_dly_q;

endmodule

// File: rtl/cam_capture.sv
// Frame-buffer writer: discards start-up frames after sensor configuration,
// packs byte pairs into RGB565 words and writes them to wrapping sequential
// addresses, flagging frames whose pixel count differs from FBUF_DEPTH.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int FBUF_DEPTH  = CAM_FRAME_PIXELS,
  parameter int ADDR_WIDTH  = 19,
  parameter int SKIP_FRAMES = 2
) (
  input  logic                  i_p_clk,
  input  logic                  i_rstn,
  input  logic                  i_cfg_done,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic [7:0]            i_data,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [15:0]           o_wdata,
  output logic                  o_wr,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic                  o_capturing
);

  localparam int SKIP_W = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

  logic       vs_s, hr_s;
  logic [7:0] d_s;
  logic       vs_rise_s, vs_fall_s, hr_rise_s, hr_fall_s;

  cam_sync_edge u_sync (
    .i_p_clk   (i_p_clk),
    .i_rstn    (i_rstn),
    .i_vsync   (i_vsync),
    .i_href    (i_href),
    .i_data    (i_data),
    .o_vs      (vs_s),
    .o_hr      (hr_s),
    .o_data    (d_s),
    .o_vs_rise (vs_rise_s),
    .o_vs_fall (vs_fall_s),
    .o_hr_rise (hr_rise_s),
    .o_hr_fall (hr_fall_s)
  );

  cam_state_e            state_q, state_d;
  logic [SKIP_W-1:0]     skip_cnt_q, skip_cnt_d;
  logic                  tog_q, tog_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  capt_q, capt_d;
  logic                  byte_ok_s;
  logic                  tog_eff_s;

  // Next-state, pixel packing and output computation for the capture FSM.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    tog_d      = tog_q;
    hi_d       = hi_q;
    wptr_d     = wptr_q;
    pix_cnt_d  = pix_cnt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    // Bytes during vertical blank are never captured.
    byte_ok_s  = hr_s & ~vs_s;
    // A new line always begins with a high byte.
    tog_eff_s  = hr_rise_s ? 1'b0 : tog_q;

    if ((state_q != S_WAIT_CFG) && !i_cfg_done) begin
      // Sensor lost its configuration: abandon the frame silently.
      state_d = S_WAIT_CFG;
      waddr_d = '0;
      wptr_d  = '0;
      tog_d   = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_CFG: begin
          if (i_cfg_done) begin
            state_d    = S_SKIP;
            skip_cnt_d = '0;
          end else begin
            state_d = S_WAIT_CFG;
          end
        end
        S_SKIP: begin
          if (skip_cnt_q == SKIP_W'(SKIP_FRAMES)) begin
            state_d = S_IDLE;
          end else if (vs_rise_s) begin
            skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          end else begin
            skip_cnt_d = skip_cnt_q;
          end
        end
        S_IDLE: begin
          if (vs_fall_s) begin
            state_d   = S_ACTIVE;
            waddr_d   = '0;
            wptr_d    = '0;
            pix_cnt_d = '0;
            tog_d     = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ACTIVE: begin
          if (byte_ok_s) begin
            if (!tog_eff_s) begin
              hi_d  = d_s;
              tog_d = 1'b1;
            end else begin
              tog_d   = 1'b0;
              wdata_d = pack_rgb565(hi_q, d_s);
              wr_d    = 1'b1;
              waddr_d = wptr_q;
              if (wptr_q == ADDR_WIDTH'(FBUF_DEPTH - 1)) begin
                wptr_d = '0;
              end else begin
                wptr_d = wptr_q + ADDR_WIDTH'(1);
              end
              if (pix_cnt_q != '1) begin
                pix_cnt_d = pix_cnt_q + ADDR_WIDTH'(1);
              end else begin
                pix_cnt_d = pix_cnt_q;
              end
            end
          end else if (hr_fall_s || vs_s) begin
            // Odd byte count at line end or blanking: drop the orphan byte.
            tog_d = 1'b0;
          end else begin
            tog_d = tog_q;
          end
          if (vs_rise_s) begin
            // A pixel completing this cycle is already in pix_cnt_d.
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = (pix_cnt_d != ADDR_WIDTH'(FBUF_DEPTH));
          end else begin
            state_d = S_ACTIVE;
          end
        end
        default: begin
          state_d = S_WAIT_CFG;
        end
      endcase
    end

    capt_d = (state_d == S_ACTIVE);
  end

  // State, datapath and registered outputs with synchronous active-low reset.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      state_q    <= S_WAIT_CFG;
      skip_cnt_q <= '0;
      tog_q      <= 1'b0;
      hi_q       <= 8'd0;
      wptr_q     <= '0;
      pix_cnt_q  <= '0;
      waddr_q    <= '0;
      wdata_q    <= 16'd0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      capt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      tog_q      <= tog_d;
      hi_q       <= hi_d;
      wptr_q     <= wptr_d;
      pix_cnt_q  <= pix_cnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      capt_q     <= capt_d;
    end
  end

  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_wr         = wr_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;
  assign o_capturing  = capt_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture with FBUF_DEPTH=8 and SKIP_FRAMES=2.
module tb_cam_capture;

  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_done;
  logic          vsync;
  logic          href;
  logic [7:0]    data;
  logic [AW-1:0] o_waddr;
  logic [15:0]   o_wdata;
  logic          o_wr;
  logic          o_frame_done;
  logic          o_frame_err;
  logic          o_capturing;

  int vectors    = 0;
  int miscompares = 0;
  int done_cnt   = 0;
  int err_cnt    = 0;

  logic [AW-1:0] aq[$];
  logic [15:0]   dq[$];

  cam_capture #(.FBUF_DEPTH(8), .ADDR_WIDTH(AW), .SKIP_FRAMES(2)) dut (
    .i_p_clk      (clk),
    .i_rstn       (rstn),
    .i_cfg_done   (cfg_done),
    .i_vsync      (vsync),
    .i_href       (href),
    .i_data       (data),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_wr         (o_wr),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err),
    .o_capturing  (o_capturing)
  );

  always #5 clk = ~clk;

  // Write and frame-event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (o_wr) begin
      aq.push_back(o_waddr);
      dq.push_back(o_wdata);
    end
    if (o_frame_done) done_cnt <= done_cnt + 1;
    if (o_frame_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    data = b;
    cyc(1);
  endtask

  task automatic end_line();
    href = 1'b0;
    data = 8'h00;
    cyc(3);
  endtask

  task automatic frame_begin();
    vsync = 1'b0;
    cyc(4);
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    cyc(4);
  endtask

  task automatic short_frame();
    frame_begin();
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i));
    end_line();
    frame_end();
  endtask

  task automatic clear_q();
    aq.delete();
    dq.delete();
  endtask

  logic [15:0] exp2 [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                            16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
  logic [7:0]  l2   [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [15:0] exp3 [5] = '{16'hA0A1, 16'hA2A3, 16'hA4A5, 16'hB0B1, 16'hB2B3};

  initial begin
    rstn = 1'b0; cfg_done = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'h00;
    cyc(3);
    // Reset state
    chk("rst wr",    32'(o_wr), 32'd0);
    chk("rst waddr", 32'(o_waddr), 32'd0);
    chk("rst wdata", 32'(o_wdata), 32'd0);
    chk("rst done",  32'(o_frame_done), 32'd0);
    chk("rst err",   32'(o_frame_err), 32'd0);
    chk("rst capt",  32'(o_capturing), 32'd0);
    rstn = 1'b1;
    cyc(2);

    // 1: two start-up frames are skipped
    cfg_done = 1'b1;
    cyc(2);
    short_frame();
    short_frame();
    chk("skip writes", 32'(aq.size()), 32'd0);
    chk("skip done",   32'(done_cnt), 32'd0);
    chk("skip capt",   32'(o_capturing), 32'd0);

    // 2: third frame, 2 lines x 8 bytes, with latency check
    frame_begin();
    chk("t2 capt", 32'(o_capturing), 32'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("t2 wr early", 32'(o_wr), 32'd0);
    send_byte(8'h56);
    chk("t2 wr lat",   32'(o_wr), 32'd1);
    chk("t2 wdata0",   32'(o_wdata), 32'h1234);
    chk("t2 waddr0",   32'(o_waddr), 32'd0);
    send_byte(8'h78); send_byte(8'h9A); send_byte(8'hBC);
    send_byte(8'hDE); send_byte(8'hF0);
    end_line();
    for (int i = 0; i < 8; i++) send_byte(l2[i]);
    end_line();
    frame_end();
    chk("t2 nwrites", 32'(aq.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t2 addr", 32'(aq[i]), 32'(i));
      chk("t2 data", 32'(dq[i]), 32'(exp2[i]));
    end
    chk("t2 done", 32'(done_cnt), 32'd1);
    chk("t2 err",  32'(err_cnt), 32'd0);
    chk("t2 capt", 32'(o_capturing), 32'd0);
    clear_q();

    // 3: 7-byte line drops the orphan, short frame flags error
    frame_begin();
    for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i));
    end_line();
    for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i));
    end_line();
    frame_end();
    chk("t3 nwrites", 32'(aq.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t3 addr", 32'(aq[i]), 32'(i));
      chk("t3 data", 32'(dq[i]), 32'(exp3[i]));
    end
    chk("t3 done", 32'(done_cnt), 32'd2);
    chk("t3 err",  32'(err_cnt), 32'd1);
    clear_q();

    // 4: 10 pixels wrap the address
    frame_begin();
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    end_line();
    frame_end();
    chk("t4 nwrites", 32'(aq.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk("t4 addr", 32'(aq[i]), 32'(i % 8));
      chk("t4 data", 32'(dq[i]), {16'd0, 8'(2 * i), 8'(2 * i + 1)});
    end
    chk("t4 done", 32'(done_cnt), 32'd3);
    chk("t4 err",  32'(err_cnt), 32'd2);
    clear_q();

    // 5: cfg_done drops mid-line with a pixel pending
    frame_begin();
    for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i));
    chk("t5 waddr pre", 32'(o_waddr), 32'd1);
    cfg_done = 1'b0;
    send_byte(8'hC6);
    chk("t5 wr",    32'(o_wr), 32'd0);
    chk("t5 waddr", 32'(o_waddr), 32'd0);
    chk("t5 capt",  32'(o_capturing), 32'd0);
    send_byte(8'hC7);
    end_line();
    frame_end();
    chk("t5 nwrites", 32'(aq.size()), 32'd2);
    chk("t5 done",    32'(done_cnt), 32'd3);
    clear_q();
    short_frame();
    chk("t5 cfg low writes", 32'(aq.size()), 32'd0);
    chk("t5 cfg low capt",   32'(o_capturing), 32'd0);
    cfg_done = 1'b1;
    cyc(2);
    short_frame();
    short_frame();
    frame_begin();
    chk("t5 recapture", 32'(o_capturing), 32'd1);
    clear_q();

    // 6: reset asserted mid-pixel
    send_byte(8'hD0);
    send_byte(8'hD1);
    send_byte(8'hD2);
    chk("t6 wdata pre", 32'(o_wdata), 32'hD0D1);
    rstn = 1'b0;
    send_byte(8'hD3);
    chk("t6 wr",    32'(o_wr), 32'd0);
    chk("t6 waddr", 32'(o_waddr), 32'd0);
    chk("t6 wdata", 32'(o_wdata), 32'd0);
    chk("t6 done",  32'(o_frame_done), 32'd0);
    chk("t6 err",   32'(o_frame_err), 32'd0);
    chk("t6 capt",  32'(o_capturing), 32'd0);
    cyc(1);
    rstn = 1'b1;
    send_byte(8'hD4);
    send_byte(8'hD5);
    end_line();
    frame_end();
    chk("t6 nwrites", 32'(aq.size()), 32'd1);
    chk("t6 done",    32'(done_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
